// File: rtl/lmmi_to_ahbl_bridge.sv
// LMMI target to AHB-Lite manager bridge: each LMMI access becomes one NONSEQ SINGLE transfer.
// Optional sticky bus-error flag on lmmi_error_o is enabled by defining LMMI2AHBL_ERR_FLAG_EN.
module lmmi_to_ahbl_bridge #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 15,
    parameter logic [31:0] AHBL_BASE  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  lmmi_request_i,
    input  logic                  lmmi_wr_rdn_i,
    input  logic [ADDR_WIDTH-1:0] lmmi_offset_i,
    input  logic [DATA_WIDTH-1:0] lmmi_wdata_i,
    output logic                  lmmi_ready_o,
    output logic [DATA_WIDTH-1:0] lmmi_rdata_o,
    output logic                  lmmi_rdata_valid_o,
    output logic                  lmmi_error_o,
    output logic [31:0]           ahbl_haddr_o,
    output logic [1:0]            ahbl_htrans_o,
    output logic                  ahbl_hwrite_o,
    output logic [2:0]            ahbl_hsize_o,
    output logic [2:0]            ahbl_hburst_o,
    output logic [3:0]            ahbl_hprot_o,
    output logic                  ahbl_hmastlock_o,
    output logic [DATA_WIDTH-1:0] ahbl_hwdata_o,
    input  logic                  ahbl_hready_i,
    input  logic                  ahbl_hresp_i,
    input  logic [DATA_WIDTH-1:0] ahbl_hrdata_i
);

    // Handshakes: an LMMI request is taken when lmmi_request_i and lmmi_ready_o are both high
    // at a clock edge; an AHB phase ends at an edge where ahbl_hready_i is high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [31:0]           req_addr;
    logic                  accept;

    assign ahbl_hsize_o     = 3'b010;
    assign ahbl_hburst_o    = 3'b000;
    assign ahbl_hprot_o     = 4'b0011;
    assign ahbl_hmastlock_o = 1'b0;

    assign accept = (state == ST_IDLE) && lmmi_request_i && lmmi_ready_o;

    // Word offset becomes a byte address, zero-extended, with the base OR'ed on top.
    always_comb begin
        req_addr = AHBL_BASE;
        req_addr[ADDR_WIDTH+1:0] = AHBL_BASE[ADDR_WIDTH+1:0] | {lmmi_offset_i, 2'b00};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state              <= ST_IDLE;
            lmmi_ready_o       <= 1'b0;
            lmmi_rdata_o       <= '0;
            lmmi_rdata_valid_o <= 1'b0;
            ahbl_haddr_o       <= '0;
            ahbl_htrans_o      <= HTRANS_IDLE;
            ahbl_hwrite_o      <= 1'b0;
            ahbl_hwdata_o      <= '0;
            wdata_q            <= '0;
`ifdef LMMI2AHBL_ERR_FLAG_EN
            lmmi_error_o       <= 1'b0;
`endif
        end else begin
            lmmi_rdata_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wdata_q       <= lmmi_wdata_i;
                        ahbl_haddr_o  <= req_addr;
                        ahbl_hwrite_o <= lmmi_wr_rdn_i;
                        ahbl_htrans_o <= HTRANS_NONSEQ;
                        lmmi_ready_o  <= 1'b0;
`ifdef LMMI2AHBL_ERR_FLAG_EN
                        lmmi_error_o  <= 1'b0;
`endif
                        state         <= ST_ADDR;
                    end else begin
                        lmmi_ready_o  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (ahbl_hready_i) begin
                        ahbl_htrans_o <= HTRANS_IDLE;
                        ahbl_hwdata_o <= wdata_q;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // An ERROR first cycle has hready low and is simply waited out here.
                    if (ahbl_hready_i) begin
                        lmmi_ready_o <= 1'b1;
                        state        <= ST_IDLE;
                        if (!ahbl_hwrite_o) begin
                            lmmi_rdata_o       <= ahbl_hresp_i ? {DATA_WIDTH{1'b1}} : ahbl_hrdata_i;
                            lmmi_rdata_valid_o <= 1'b1;
                        end
`ifdef LMMI2AHBL_ERR_FLAG_EN
                        if (ahbl_hresp_i) lmmi_error_o <= 1'b1;
`endif
                    end
                end
                default: begin
                    ahbl_htrans_o <= HTRANS_IDLE;
                    lmmi_ready_o  <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef LMMI2AHBL_ERR_FLAG_EN
    assign lmmi_error_o = 1'b0;
`endif

endmodule
